// File: rtl/multdiv_pkg.sv
// multdiv_pkg: shared states, iteration counts and radix-4 Booth digit decode for multdiv_unit.
package multdiv_pkg;
   typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} md_state_t;
   typedef enum logic [2:0] {ZERO, PLUS1, PLUS2, MINUS1, MINUS2} booth_sel_t;
   localparam int MUL_ITERS = 16;
   localparam int DIV_ITERS = 32;
   // window is {b[i+1], b[i], b[i-1]} of the multiplier
   function automatic booth_sel_t booth_sel(input logic [2:0] w);
      return (w == 3'b001 || w == 3'b010) ? PLUS1 :
             (w == 3'b011)                ? PLUS2 :
             (w == 3'b100)                ? MINUS2 :
             (w == 3'b101 || w == 3'b110) ? MINUS1 : ZERO;
   endfunction
endpackage

// File: rtl/multdiv_booth_r4_step.sv
// booth_r4_step: maps a Booth window and multiplicand to a sign-extended 34-bit addend.
module booth_r4_step
   import multdiv_pkg::*;
(
   input  logic [2:0]  win_i,
   input  logic [31:0] mcand_i,
   output logic [33:0] pp_o
);
   booth_sel_t  sel;
   logic [33:0] a1, a2;
   always_comb begin
      sel  = booth_sel(win_i);
      a1   = {{2{mcand_i[31]}}, mcand_i};
      a2   = {a1[32:0], 1'b0};
      pp_o = sel == PLUS1  ? a1 :
             sel == PLUS2  ? a2 :
             sel == MINUS1 ? -a1 :
             sel == MINUS2 ? -a2 : '0;
   end
endmodule

// File: rtl/multdiv_unit.sv
// multdiv_unit: multi-cycle signed 32-bit multiply (radix-4 Booth) and divide (non-restoring).
module multdiv_unit
   import multdiv_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [WIDTH-1:0] data_operandA,
   input  logic [WIDTH-1:0] data_operandB,
   input  logic             ctrl_MULT,
   input  logic             ctrl_DIV,
   output logic [WIDTH-1:0] data_result,
   output logic             data_exception,
   output logic             data_resultRDY
);
   md_state_t   state_q, state_d;
   logic [5:0]  cnt_q, cnt_d;
   logic [33:0] acc_q, acc_d;
   logic [32:0] rem_q, rem_d;
   logic [31:0] lo_q, lo_d, mcand_q, mcand_d, res_q, res_d;
   logic        prev_q, prev_d, neg_q, neg_d, ovf_q, ovf_d, exc_q, exc_d, rdy_q, rdy_d;
   logic [33:0] pp, acc_sum, acc_sh;
   logic [31:0] lo_sh, quo_n, abs_a, abs_b;
   logic [63:0] mprod;
   logic [32:0] rem_sh, rem_n;

   booth_r4_step u_booth (
      .win_i   ({lo_q[1:0], prev_q}),
      .mcand_i (mcand_q),
      .pp_o    (pp)
   );

   always_comb begin
      acc_sum = acc_q + pp;
      acc_sh  = {{2{acc_sum[33]}}, acc_sum[33:2]};
      lo_sh   = {acc_sum[1:0], lo_q[31:2]};
      mprod   = {acc_sh[31:0], lo_sh};
      // the remainder sign picks subtract or add back; quotient bit is the new sign inverted
      rem_sh  = {rem_q[31:0], lo_q[31]};
      rem_n   = rem_q[32] ? rem_sh + {1'b0, mcand_q} : rem_sh - {1'b0, mcand_q};
      quo_n   = {lo_q[30:0], ~rem_n[32]};
      abs_a   = data_operandA[31] ? -data_operandA : data_operandA;
      abs_b   = data_operandB[31] ? -data_operandB : data_operandB;
      state_d = state_q;
      cnt_d   = cnt_q;
      acc_d   = acc_q;
      rem_d   = rem_q;
      lo_d    = lo_q;
      mcand_d = mcand_q;
      prev_d  = prev_q;
      neg_d   = neg_q;
      ovf_d   = ovf_q;
      res_d   = res_q;
      exc_d   = exc_q;
      if (ctrl_MULT) begin
         state_d = MUL;
         cnt_d   = 6'(MUL_ITERS);
         acc_d   = '0;
         lo_d    = data_operandB;
         mcand_d = data_operandA;
         prev_d  = 1'b0;
      end else if (ctrl_DIV) begin
         if (data_operandB == '0) begin
            state_d = DONE;
            cnt_d   = '0;
            res_d   = '0;
            exc_d   = 1'b1;
         end else begin
            state_d = DIV;
            cnt_d   = 6'(DIV_ITERS);
            rem_d   = '0;
            lo_d    = abs_a;
            mcand_d = abs_b;
            neg_d   = data_operandA[31] ^ data_operandB[31];
            ovf_d   = data_operandA == 32'h8000_0000 && data_operandB == 32'hFFFF_FFFF;
         end
      end else begin
         unique case (state_q)
            MUL: begin
               acc_d  = acc_sh;
               lo_d   = lo_sh;
               prev_d = lo_q[1];
               cnt_d  = cnt_q - 6'd1;
               if (cnt_q == 6'd1) begin
                  state_d = DONE;
                  res_d   = mprod[31:0];
                  exc_d   = ~((&mprod[63:31]) | ~(|mprod[63:31]));
               end
            end
            DIV: begin
               rem_d = rem_n;
               lo_d  = quo_n;
               cnt_d = cnt_q - 6'd1;
               if (cnt_q == 6'd1) begin
                  state_d = DONE;
                  res_d   = neg_q ? -quo_n : quo_n;
                  exc_d   = ovf_q;
               end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
      rdy_d = state_d == DONE;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         acc_q   <= '0;
         rem_q   <= '0;
         lo_q    <= '0;
         mcand_q <= '0;
         prev_q  <= 1'b0;
         neg_q   <= 1'b0;
         ovf_q   <= 1'b0;
         res_q   <= '0;
         exc_q   <= 1'b0;
         rdy_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
         rem_q   <= rem_d;
         lo_q    <= lo_d;
         mcand_q <= mcand_d;
         prev_q  <= prev_d;
         neg_q   <= neg_d;
         ovf_q   <= ovf_d;
         res_q   <= res_d;
         exc_q   <= exc_d;
         rdy_q   <= rdy_d;
      end
   end

   assign data_result    = res_q;
   assign data_exception = exc_q;
   assign data_resultRDY = rdy_q;
endmodule

// File: tb/tb_multdiv_unit.sv
// tb_multdiv_unit: scoreboard bench checking result, exception and RDY edge of every operation.
module tb_multdiv_unit;
   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] data_operandA = '0, data_operandB = '0;
   logic        ctrl_MULT = 1'b0, ctrl_DIV = 1'b0;
   logic [31:0] data_result;
   logic        data_exception, data_resultRDY;

   typedef struct {
      logic [31:0] res;
      logic        exc;
      int          at;
   } exp_t;

   exp_t sb[$];
   int   cyc = 0;
   int   checks = 0;
   int   failures = 0;

   multdiv_unit #(.WIDTH(32)) dut (
      .clock          (clock),
      .reset          (reset),
      .data_operandA  (data_operandA),
      .data_operandB  (data_operandB),
      .ctrl_MULT      (ctrl_MULT),
      .ctrl_DIV       (ctrl_DIV),
      .data_result    (data_result),
      .data_exception (data_exception),
      .data_resultRDY (data_resultRDY)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   always @(posedge clock) begin
      exp_t e;
      cyc++;
      #1;
      if (data_resultRDY) begin
         if (sb.size() == 0) chk("spurious_rdy", 64'd1, 64'd0);
         else begin
            e = sb.pop_front();
            chk("res", 64'(data_result), 64'(e.res));
            chk("exc", 64'(data_exception), 64'(e.exc));
            chk("rdy_edge", 64'(cyc), 64'(e.at));
         end
      end
   end

   // reference behaviour from plain signed arithmetic
   task automatic model(input logic mul, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] r, output logic x, output int lat);
      logic signed [63:0] p;
      if (mul) begin
         p   = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
         r   = p[31:0];
         x   = !(p[63:31] == '0 || p[63:31] == '1);
         lat = 17;
      end else if (b == 0) begin
         r = 0; x = 1'b1; lat = 1;
      end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
         r = 32'h8000_0000; x = 1'b1; lat = 33;
      end else begin
         r = 32'($signed(a) / $signed(b)); x = 1'b0; lat = 33;
      end
   endtask

   task automatic start(input logic mul, input logic [31:0] a, input logic [31:0] b, input logic abort);
      exp_t e;
      int   lat;
      model(mul, a, b, e.res, e.exc, lat);
      @(negedge clock);
      if (abort && sb.size() != 0) void'(sb.pop_back());
      data_operandA = a;
      data_operandB = b;
      ctrl_MULT = mul;
      ctrl_DIV = ~mul;
      e.at = cyc + lat;
      sb.push_back(e);
      @(negedge clock);
      ctrl_MULT = 1'b0;
      ctrl_DIV = 1'b0;
      data_operandA = $urandom;
      data_operandB = $urandom;
   endtask

   task automatic wait_done();
      for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clock);
      if (sb.size() != 0) begin
         chk("timeout", 64'(sb.size()), 64'd0);
         sb.delete();
      end
   endtask

   initial begin
      logic [31:0] a, b;
      repeat (2) @(negedge clock);
      chk("reset_res", 64'(data_result), 64'd0);
      chk("reset_exc", 64'(data_exception), 64'd0);
      chk("reset_rdy", 64'(data_resultRDY), 64'd0);
      reset = 1'b0;
      start(1'b1, 32'd7, 32'hFFFF_FFFD, 1'b0);
      wait_done();
      chk("mul_7x-3", 64'(data_result), 64'h0000_0000_FFFF_FFEB);
      start(1'b1, 32'h0001_0000, 32'h0001_0000, 1'b0);
      wait_done();
      chk("mul_ovf_exc", 64'(data_exception), 64'd1);
      start(1'b1, 32'h7FFF_FFFF, 32'd1, 1'b0);
      wait_done();
      chk("mul_max", 64'(data_result), 64'h7FFF_FFFF);
      start(1'b0, 32'hFFFF_FF9C, 32'd7, 1'b0);
      wait_done();
      chk("div_-100/7", 64'(data_result), 64'hFFFF_FFF2);
      start(1'b0, 32'd100, 32'd7, 1'b0);
      wait_done();
      start(1'b0, 32'd5, 32'd0, 1'b0);
      wait_done();
      chk("div0_exc", 64'(data_exception), 64'd1);
      start(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
      wait_done();
      chk("div_ovf_res", 64'(data_result), 64'h8000_0000);
      start(1'b1, 32'd3, 32'd4, 1'b0);
      repeat (3) @(negedge clock);
      start(1'b0, 32'd100, 32'd7, 1'b1);
      wait_done();
      chk("abort_res", 64'(data_result), 64'd14);
      start(1'b1, 32'd5, 32'd5, 1'b0);
      repeat (6) @(negedge clock);
      reset = 1'b1;
      sb.delete();
      @(posedge clock);
      #1;
      chk("rst_mid_res", 64'(data_result), 64'd0);
      chk("rst_mid_rdy", 64'(data_resultRDY), 64'd0);
      @(negedge clock);
      reset = 1'b0;
      repeat (20) @(negedge clock);
      start(1'b1, 32'd2, 32'd3, 1'b0);
      wait_done();
      chk("mul_2x3", 64'(data_result), 64'd6);
      for (int i = 0; i < 12; i++) begin
         a = $urandom;
         b = (i % 4 == 3) ? 32'd0 : (i % 2 == 0) ? $urandom : 32'($signed($urandom_range(0, 2000)) - 1000);
         start(i[0], a, b, 1'b0);
         wait_done();
      end
      repeat (40) @(negedge clock);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
